// File: rtl/pad_io_bank.sv
`default_nettype none
// ============================================================================
// Module   : pad_io_bank
// Brief    : Registered multi-channel pad bank: output drive, 2-flop input
//            synchroniser, debounce filter and rise/fall edge pulses.
//            Optional interrupt status/irq logic under PAD_IO_BANK_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pad_io_bank #(
  parameter int NUM_CH  = 8,
  parameter int DEB_CYC = 4,
  parameter int DEB_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] oen,
  input  logic [NUM_CH-1:0] ien,
  input  logic [NUM_CH-1:0] od,
  output logic [NUM_CH-1:0] id,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  inout  wire  [NUM_CH-1:0] pad
`ifdef PAD_IO_BANK_IRQ_EN
  ,
  input  logic [NUM_CH-1:0] int_rise_en,
  input  logic [NUM_CH-1:0] int_fall_en,
  input  logic [NUM_CH-1:0] int_clr,
  output logic [NUM_CH-1:0] int_sts,
  output logic              irq
`endif
);

  logic [NUM_CH-1:0] r_od_q;
  logic [NUM_CH-1:0] r_oen_q;
  logic [NUM_CH-1:0] r_s1;
  logic [NUM_CH-1:0] r_s2;
  logic [NUM_CH-1:0] r_id;
  logic [NUM_CH-1:0] r_rise;
  logic [NUM_CH-1:0] r_fall;
  logic [NUM_CH-1:0] w_gate;
  logic [NUM_CH-1:0] w_id_next;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_pad
    assign pad[i] = r_oen_q[i] ? 1'bz : r_od_q[i];
  end

  // Gate before the synchroniser so a disabled input debounces down to 0.
  assign w_gate = pad & ~ien;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_od_q  <= '0;
      r_oen_q <= '1;
      r_s1    <= '0;
      r_s2    <= '0;
      r_id    <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      r_od_q  <= od;
      r_oen_q <= oen;
      r_s1    <= w_gate;
      r_s2    <= r_s1;
      r_id    <= w_id_next;
      r_rise  <= w_id_next & ~r_id;
      r_fall  <= ~w_id_next & r_id;
    end
  end

  if (DEB_CYC == 0) begin : g_bypass
    assign w_id_next = r_s2;
  end else begin : g_deb
    localparam logic [DEB_W-1:0] c_deb_last = DEB_W'(DEB_CYC - 1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DEB_W-1:0] r_cnt;
      logic             w_diff;
      logic             w_done;

      assign w_diff       = r_s2[i] != r_id[i];
      assign w_done       = w_diff && (r_cnt == c_deb_last);
      assign w_id_next[i] = w_done ? r_s2[i] : r_id[i];

      // Counter measures how long s2 has disagreed with id without a break.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (!w_diff || w_done) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign id   = r_id;
  assign rise = r_rise;
  assign fall = r_fall;

`ifdef PAD_IO_BANK_IRQ_EN
  logic [NUM_CH-1:0] r_int_sts;
  logic [NUM_CH-1:0] w_int_set;

  assign w_int_set = (r_rise & int_rise_en) | (r_fall & int_fall_en);

  // Set is OR-ed after the clear so a coincident event is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int_sts <= '0;
    end else begin
      r_int_sts <= (r_int_sts & ~int_clr) | w_int_set;
    end
  end

  assign int_sts = r_int_sts;
  assign irq     = |r_int_sts;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pad_io_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_pad_io_bank
// Brief    : Self-checking bench for pad_io_bank (table, directed, random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pad_io_bank;
  localparam int N = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] oen = '1, ien = '1, od = '0, ext = '0;
  logic [N-1:0] id, rise, fall;
  wire  [N-1:0] pad;
  logic [N-1:0] tb_oenq;

  logic [N-1:0] ext0 = '0;
  logic [N-1:0] id0, rise0, fall0;
  wire  [N-1:0] pad0;
  logic [N-1:0] c_ones  = '1;
  logic [N-1:0] c_zeros = '0;

`ifdef PAD_IO_BANK_IRQ_EN
  logic [N-1:0] int_rise_en = '0, int_fall_en = '0, int_clr = '0;
  logic [N-1:0] int_sts;
  logic         irq;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Bench drives a pad only while the DUT's registered enable leaves it released.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_oenq <= '1;
    else     tb_oenq <= oen;
  end
  for (genvar i = 0; i < N; i++) begin : g_drv
    assign pad[i]  = tb_oenq[i] ? ext[i] : 1'bz;
    assign pad0[i] = ext0[i];
  end

  pad_io_bank #(.NUM_CH(N), .DEB_CYC(D), .DEB_W(8)) u_dut (
    .clk(clk), .rst(rst), .oen(oen), .ien(ien), .od(od),
    .id(id), .rise(rise), .fall(fall), .pad(pad)
`ifdef PAD_IO_BANK_IRQ_EN
    , .int_rise_en(int_rise_en), .int_fall_en(int_fall_en),
    .int_clr(int_clr), .int_sts(int_sts), .irq(irq)
`endif
  );

  pad_io_bank #(.NUM_CH(N), .DEB_CYC(0), .DEB_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .oen(c_ones), .ien(c_zeros), .od(c_zeros),
    .id(id0), .rise(rise0), .fall(fall0), .pad(pad0)
`ifdef PAD_IO_BANK_IRQ_EN
    , .int_rise_en(c_zeros), .int_fall_en(c_zeros),
    .int_clr(c_zeros), .int_sts(), .irq()
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: id flips once the last D synchronised samples all oppose it.
  logic [N-1:0] m_s1, m_s2, m_id, m_rise, m_fall, m_odq, m_oenq;
  logic [N-1:0] q_s2[$];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_id = '0; m_rise = '0; m_fall = '0;
    m_odq = '0; m_oenq = '1;
    q_s2.delete();
  endtask

  task automatic model_edge(input logic [N-1:0] g);
    logic [N-1:0] nid;
    bit all_opp;
    q_s2.push_back(m_s2);
    while (q_s2.size() > D) void'(q_s2.pop_front());
    nid = m_id;
    for (int ch = 0; ch < N; ch++) begin
      all_opp = (q_s2.size() == D);
      foreach (q_s2[k]) if (q_s2[k][ch] == m_id[ch]) all_opp = 0;
      if (all_opp) nid[ch] = ~m_id[ch];
    end
    m_rise = nid & ~m_id;
    m_fall = ~nid & m_id;
    m_id   = nid;
    m_s2   = m_s1;
    m_s1   = g;
  endtask

  task automatic do_reset();
    rst = 1'b1; oen = '1; ien = '1; od = '0; ext = '0; ext0 = '0;
`ifdef PAD_IO_BANK_IRQ_EN
    int_rise_en = '0; int_fall_en = '0; int_clr = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] oen;
    logic [N-1:0] od;
    logic [N-1:0] ext;
    logic [N-1:0] exp_pad;
  } drv_vec_t;

  initial begin
    drv_vec_t vecs[5];
    logic [N-1:0] g;

    vecs[0] = '{oen: 8'h00, od: 8'hA5, ext: 8'h00, exp_pad: 8'hA5};
    vecs[1] = '{oen: 8'h01, od: 8'hA5, ext: 8'h00, exp_pad: 8'hA4};
    vecs[2] = '{oen: 8'hFF, od: 8'h00, ext: 8'h5A, exp_pad: 8'h5A};
    vecs[3] = '{oen: 8'hF0, od: 8'h33, ext: 8'hC0, exp_pad: 8'hC3};
    vecs[4] = '{oen: 8'h0F, od: 8'h0C, ext: 8'hF0, exp_pad: 8'h00};

    // Reset with DUT enables requested and pads held high externally.
    rst = 1'b1; oen = '0; od = '0; ext = '1; ien = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_id", id, 0);
    chk("reset_rise", rise, 0);
    chk("reset_fall", fall, 0);
    chk("reset_pad_released", pad, 8'hFF);
    oen = '1;
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      chk("reset_exit_no_edges", {rise, fall}, 0);
    end

    // Output drive table.
    do_reset();
    foreach (vecs[v]) begin
      oen = vecs[v].oen; od = vecs[v].od; ext = vecs[v].ext;
      @(posedge clk); #1;
      chk($sformatf("drive_vec%0d", v), pad, vecs[v].exp_pad);
    end

    // Debounce latency on channel 3.
    do_reset();
    ien = 8'hF7;
    ext[3] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      chk($sformatf("latency_id3_e%0d", e), id[3], (e >= 6) ? 1 : 0);
      chk($sformatf("latency_rise3_e%0d", e), rise[3], (e == 6) ? 1 : 0);
    end

    // Glitch of 3 cycles on channel 2: filtered at DEB_CYC=4, passed at 0.
    do_reset();
    ien = 8'hFB;
    ext[2]  = 1'b1;
    ext0[2] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (e == 3) begin ext[2] = 1'b0; ext0[2] = 1'b0; end
      chk($sformatf("glitch_filtered_e%0d", e), {id[2], rise[2], fall[2]}, 0);
      chk($sformatf("glitch_bypass_id_e%0d", e), id0[2], (e >= 3 && e <= 5) ? 1 : 0);
      chk($sformatf("glitch_bypass_rise_e%0d", e), rise0[2], (e == 3) ? 1 : 0);
      chk($sformatf("glitch_bypass_fall_e%0d", e), fall0[2], (e == 6) ? 1 : 0);
    end

    // Disabling the input on a high channel yields a normal debounced fall.
    do_reset();
    ien = 8'hDF;
    ext[5] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("gate_id5_high", id[5], 1);
    ien = 8'hFF;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      chk($sformatf("gate_id5_e%0d", e), id[5], (e < 6) ? 1 : 0);
      chk($sformatf("gate_fall5_e%0d", e), fall[5], (e == 6) ? 1 : 0);
    end

`ifdef PAD_IO_BANK_IRQ_EN
    // Status set coincident with clear must win; a later clear removes it.
    do_reset();
    ien = 8'hFD;
    int_rise_en = 8'h02;
    ext[1] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("irq_rise1", rise[1], 1);
    int_clr = 8'h02;
    @(posedge clk); #1;
    chk("irq_sts_set_wins", int_sts[1], 1);
    chk("irq_high", irq, 1);
    @(posedge clk); #1;
    chk("irq_sts_cleared", int_sts[1], 0);
    chk("irq_low", irq, 0);
    int_clr = '0;
`endif

    // Randomised traffic against the reference model, with sporadic resets.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(99) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        chk("rand_async_reset", {id, rise, fall}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
      end
      od  = N'($urandom);
      ext = ext ^ N'($urandom & $urandom & $urandom);
      oen = oen ^ N'($urandom & $urandom & $urandom & $urandom & $urandom);
      ien = ien ^ N'($urandom & $urandom & $urandom & $urandom & $urandom);
      g = ~ien & ((m_oenq & ext) | (~m_oenq & m_odq));
      @(posedge clk);
      model_edge(g);
      m_odq  = od;
      m_oenq = oen;
      #1;
      chk("rand_pad", pad, (m_oenq & ext) | (~m_oenq & m_odq));
      chk("rand_id", id, m_id);
      chk("rand_rise", rise, m_rise);
      chk("rand_fall", fall, m_fall);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pad_io_bank.md
Name: pad_io_bank

Overview:
- Parametrised, registered multi-channel digital pad bank; successor to the single-channel combinational pad wrapper.
- Per channel: registered output-data and output-enable drive, 2-flop input synchroniser, debounce filter, one-cycle rise/fall pulses.
- Sits between the GPIO/peripheral pinmux and the chip IO ring. Replaces per-pin pad instances at top level.

Parameters:
- NUM_CH, 8, number of pad channels (1..32).
- DEB_CYC, 4, debounce length in clk cycles (0 = debounce bypassed).
- DEB_W, 8, debounce counter width; DEB_CYC must be < 2**DEB_W.

Ports:
- clk  input  1  bank clock.
- rst  input  1  asynchronous reset, active-high.
- oen  input  NUM_CH  output enable, active-low (0 = drive pad).
- ien  input  NUM_CH  input enable, active-low (0 = sample pad).
- od  input  NUM_CH  output data.
- id  output  NUM_CH  synchronised, debounced input data.
- rise  output  NUM_CH  one-cycle pulse on id 0->1.
- fall  output  NUM_CH  one-cycle pulse on id 1->0.
- pad  inout  NUM_CH  pad pins.

Behaviour:
- Reset (async, rst=1): oen_q all 1 (pads high-Z), od_q 0, sync flops 0, debounce counters 0, id 0, rise 0, fall 0. Reset mid-operation aborts any debounce in progress; no edge pulses are generated on reset entry or exit.
- Output path: od_q, oen_q register od and oen every clk edge. pad[i] = od_q[i] when oen_q[i]=0, else Z. Latency from od/oen to pad is 1 edge.
- Input gate: g[i] = pad[i] when ien[i]=0, else 0. Gating is applied before the synchroniser. Asserting ien on a channel whose id=1 produces a normal debounced fall.
- Synchroniser: s1 <= g; s2 <= s1.
- Debounce, per channel, with DEB_CYC>0:
  - s2==id: counter <= 0.
  - s2!=id and counter==DEB_CYC-1: id <= s2, counter <= 0.
  - Otherwise: counter <= counter+1.
  - Any s2 run shorter than DEB_CYC cycles is discarded.
- Debounce with DEB_CYC=0: id <= s2 every edge.
- Latency: a clean pad change settled before edge 1 appears on id at edge 2+max(DEB_CYC,1).
- Edges: rise[i] <= id_next[i] & ~id[i]; fall[i] <= ~id_next[i] & id[i]. Each pulse is high for exactly the first cycle id shows its new value. rise and fall are never both high on one channel.
- Channels are fully independent; no shared state except clk/rst.
- Loopback: with oen=0 and ien=0, id follows od after 1 + 2 + max(DEB_CYC,1) edges.

Optional Feature:
- Macro: PAD_IO_BANK_IRQ_EN.
- When defined, adds these ports:
  - int_rise_en  input  NUM_CH
  - int_fall_en  input  NUM_CH
  - int_clr  input  NUM_CH
  - int_sts  output  NUM_CH, sticky, reset 0
  - irq  output  1
- int_sts[i] sets on (rise[i]&int_rise_en[i]) | (fall[i]&int_fall_en[i]) and clears on int_clr[i]=1. Set wins when set and clear occur in the same cycle.
- irq = |int_sts (combinational from registered status).
- When undefined, these ports and their logic are absent; the rest of the behaviour is unchanged.

Test Plan:
- Reset: apply rst=1 with pads pulled to 1 and oen=0 -> pad all Z, id=0, rise=fall=0. Release rst -> no edge pulses while oen_q still 1.
- Drive: NUM_CH=8, DEB_CYC=4; set oen=8'h00, od=8'hA5 at edge 0 -> pad=8'hA5 after edge 1. Set oen[0]=1 -> pad[0]=Z after the next edge.
- Debounce latency: external pad[3] 0->1 before edge 1 -> id[3]=1 and rise[3]=1 at edge 6 only; rise[3]=0 at edge 7.
- Glitch filter: pad[2] high for 3 cycles, then low -> id[2] stays 0, no rise/fall. Repeat with DEB_CYC=0 -> id[2] pulses high for 3 cycles, with rise then fall.
- Input gate: id[5]=1; set ien[5]=1 -> fall[5] pulse and id[5]=0 after 2+4 edges, regardless of pad[5].
- IRQ (macro on): int_rise_en[1]=1; rise[1] in the same cycle as int_clr[1]=1 -> int_sts[1]=1, irq=1. int_clr[1] on the next cycle -> int_sts[1]=0, irq=0.
